// File: rtl/branch_resolve_pkg.sv
// Shared types for the branch resolution unit: request kind codes and FSM states.
package branch_resolve_pkg;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_COND = 2'b01,
    BR_JMP  = 2'b10,
    BR_JREG = 2'b11
  } br_kind_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  localparam int CNT_W = 4;

endpackage

// File: rtl/branch_resolve_if.sv
// Branch/jump request bus from decode/execute into branch_resolve.
interface branch_resolve_if;
  import branch_resolve_pkg::*;

  logic               br_valid;
  logic               br_ready;
  br_kind_t           br_kind;
  logic               br_link;
  logic        [31:0] br_pc;
  logic signed [31:0] br_offset;
  logic        [31:0] br_reg;
  logic               z_flag;

  modport master (
    output br_valid, br_kind, br_link, br_pc, br_offset, br_reg, z_flag,
    input  br_ready
  );

  modport slave (
    input  br_valid, br_kind, br_link, br_pc, br_offset, br_reg, z_flag,
    output br_ready
  );

endinterface

// File: rtl/br_target_calc.sv
// Combinational target/taken/misalign evaluation for one branch request.
module br_target_calc
  import branch_resolve_pkg::*;
(
  input  br_kind_t           br_kind,
  input  logic        [31:0] br_pc,
  input  logic signed [31:0] br_offset,
  input  logic        [31:0] br_reg,
  input  logic               z_flag,
  output logic        [31:0] target,
  output logic               taken,
  output logic               misalign
);

  logic [31:0] raw;

  always_comb begin
    raw   = br_pc + $unsigned(br_offset);
    taken = 1'b0;
    case (br_kind)
      BR_COND: taken = z_flag;
      BR_JMP:  taken = 1'b1;
      BR_JREG: begin
        raw   = br_reg;
        taken = 1'b1;
      end
      default: taken = 1'b0;
    endcase
  end

  // Misalignment only matters when the redirect actually happens.
  assign target   = {raw[31:2], 2'b00};
  assign misalign = taken && (raw[1:0] != 2'b00);

endmodule

// File: rtl/branch_resolve.sv
// Branch resolution and fetch PC owner (static predict-not-taken, fixed-length flush).
// Optional taken/not-taken statistics counters are built when BRANCH_STATS_EN is defined.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          PC_STEP      = 4,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  branch_resolve_if.slave  br,
  output logic [31:0]      pc_o,
  output logic             pc_valid,
  output logic             flush_o,
  output logic             link_we,
  output logic [31:0]      link_data,
  output logic             misalign_o
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]      taken_cnt,
  output logic [31:0]      nottaken_cnt
`endif
);

  localparam logic [31:0]      STEP      = 32'(PC_STEP);
  localparam logic [CNT_W-1:0] FLUSH_LEN = CNT_W'(FLUSH_CYCLES);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [31:0]        target;
  logic               taken;
  logic               misalign;
  logic               accept;
  logic               taken_acc;
  logic               link_fire;

  br_target_calc u_target_calc (
    .br_kind   (br.br_kind),
    .br_pc     (br.br_pc),
    .br_offset (br.br_offset),
    .br_reg    (br.br_reg),
    .z_flag    (br.z_flag),
    .target    (target),
    .taken     (taken),
    .misalign  (misalign)
  );

  // Requests arriving while flushing are squashed: br_ready is low in FLUSH.
  assign accept    = br.br_valid && br.br_ready;
  assign taken_acc = accept && taken;
  assign link_fire = accept && br.br_link &&
                     ((br.br_kind == BR_JMP) || (br.br_kind == BR_JREG));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Flush length counts cycles, not instructions, so stall_i is ignored here.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_RUN: begin
        if (taken_acc) begin
          state_nxt = ST_FLUSH;
          cnt_nxt   = FLUSH_LEN;
        end
      end
      ST_FLUSH: begin
        cnt_nxt = cnt - 1'b1;
        if (cnt <= 1) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    br.br_ready = (state == ST_RUN);
    flush_o     = (state == ST_FLUSH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_o       <= RESET_PC;
      pc_valid   <= 1'b0;
      link_we    <= 1'b0;
      link_data  <= '0;
      misalign_o <= 1'b0;
    end else begin
      pc_valid   <= 1'b1;
      link_we    <= link_fire;
      misalign_o <= taken_acc && misalign;
      if (link_fire) link_data <= br.br_pc + STEP;
      // A redirect overrides a stall in the same cycle.
      if (taken_acc)     pc_o <= target;
      else if (!stall_i) pc_o <= pc_o + STEP;
    end
  end

`ifdef BRANCH_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      taken_cnt    <= '0;
      nottaken_cnt <= '0;
    end else if (accept && (br.br_kind != BR_NONE)) begin
      if (taken) taken_cnt    <= sat_inc(taken_cnt);
      else       nottaken_cnt <= sat_inc(nottaken_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Directed self-checking bench for branch_resolve (stats section built with BRANCH_STATS_EN).
module tb_branch_resolve;
  import branch_resolve_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic [31:0] pc_o;
  logic        pc_valid;
  logic        flush_o;
  logic        link_we;
  logic [31:0] link_data;
  logic        misalign_o;
`ifdef BRANCH_STATS_EN
  logic [31:0] taken_cnt;
  logic [31:0] nottaken_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  branch_resolve_if bus ();

  branch_resolve dut (
    .clk        (clk),
    .rst        (rst),
    .stall_i    (stall_i),
    .br         (bus),
    .pc_o       (pc_o),
    .pc_valid   (pc_valid),
    .flush_o    (flush_o),
    .link_we    (link_we),
    .link_data  (link_data),
    .misalign_o (misalign_o)
`ifdef BRANCH_STATS_EN
    ,
    .taken_cnt    (taken_cnt),
    .nottaken_cnt (nottaken_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input br_kind_t kind, input logic [31:0] pc, input logic [31:0] off,
                         input logic [31:0] rg, input logic z, input logic link);
    bus.br_valid  = 1'b1;
    bus.br_kind   = kind;
    bus.br_pc     = pc;
    bus.br_offset = off;
    bus.br_reg    = rg;
    bus.z_flag    = z;
    bus.br_link   = link;
  endtask

  task automatic clr_req();
    bus.br_valid = 1'b0;
    bus.br_link  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; stall_i = 1'b0;
    bus.br_valid = 1'b0; bus.br_kind = BR_NONE; bus.br_link = 1'b0;
    bus.br_pc = '0; bus.br_offset = '0; bus.br_reg = '0; bus.z_flag = 1'b0;
    tick(); tick();
    check_eq("rst_pc",       pc_o, 32'h0);
    check_eq("rst_pc_valid", 32'(pc_valid), 32'd0);
    check_eq("rst_flush",    32'(flush_o), 32'd0);
    check_eq("rst_ready",    32'(bus.br_ready), 32'd1);
    check_eq("rst_link_we",  32'(link_we), 32'd0);
    check_eq("rst_link_dat", link_data, 32'h0);
    check_eq("rst_misalign", 32'(misalign_o), 32'd0);

    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_eq("run_pc",       pc_o, 32'(4 * i));
      check_eq("run_pc_valid", 32'(pc_valid), 32'd1);
      check_eq("run_flush",    32'(flush_o), 32'd0);
    end

    // Taken COND with an injected request during the flush window.
    set_req(BR_COND, 32'h10, 32'h20, 32'h0, 1'b1, 1'b0);
    check_eq("cond_ready_pre", 32'(bus.br_ready), 32'd1);
    tick();
    check_eq("cond_pc",     pc_o, 32'h30);
    check_eq("cond_flush1", 32'(flush_o), 32'd1);
    check_eq("cond_ready1", 32'(bus.br_ready), 32'd0);
    set_req(BR_JMP, 32'h200, 32'h3, 32'h0, 1'b0, 1'b1);
    tick();
    check_eq("squash_pc",       pc_o, 32'h34);
    check_eq("cond_flush2",     32'(flush_o), 32'd1);
    check_eq("cond_ready2",     32'(bus.br_ready), 32'd0);
    check_eq("squash_link_we",  32'(link_we), 32'd0);
    check_eq("squash_misalign", 32'(misalign_o), 32'd0);
    tick();
    check_eq("squash2_pc",    pc_o, 32'h38);
    check_eq("cond_flush_end", 32'(flush_o), 32'd0);
    check_eq("cond_ready_end", 32'(bus.br_ready), 32'd1);
    check_eq("squash2_link",   32'(link_we), 32'd0);
    clr_req();
    tick();
    check_eq("idle_pc", pc_o, 32'h3C);

    // Not-taken COND with a misaligned would-be target: no redirect, no pulse.
    set_req(BR_COND, 32'h10, 32'h21, 32'h0, 1'b0, 1'b1);
    tick();
    check_eq("nt_pc",       pc_o, 32'h40);
    check_eq("nt_flush",    32'(flush_o), 32'd0);
    check_eq("nt_ready",    32'(bus.br_ready), 32'd1);
    check_eq("nt_misalign", 32'(misalign_o), 32'd0);
    check_eq("nt_link_we",  32'(link_we), 32'd0);

    set_req(BR_NONE, 32'h80, 32'h40, 32'h0, 1'b1, 1'b1);
    tick();
    check_eq("none_pc",      pc_o, 32'h44);
    check_eq("none_flush",   32'(flush_o), 32'd0);
    check_eq("none_link_we", 32'(link_we), 32'd0);

    // JREG with link and a simultaneous stall.
    set_req(BR_JREG, 32'h40, 32'h0, 32'h103, 1'b0, 1'b1);
    stall_i = 1'b1;
    tick();
    check_eq("jreg_pc",       pc_o, 32'h100);
    check_eq("jreg_misalign", 32'(misalign_o), 32'd1);
    check_eq("jreg_link_we",  32'(link_we), 32'd1);
    check_eq("jreg_link_dat", link_data, 32'h44);
    check_eq("jreg_flush",    32'(flush_o), 32'd1);
    clr_req();
    stall_i = 1'b0;
    tick();
    check_eq("jreg_pc2",       pc_o, 32'h104);
    check_eq("jreg_misalign2", 32'(misalign_o), 32'd0);
    check_eq("jreg_link_we2",  32'(link_we), 32'd0);
    check_eq("jreg_link_hold", link_data, 32'h44);
    tick();
    check_eq("jreg_pc3",    pc_o, 32'h108);
    check_eq("jreg_flush3", 32'(flush_o), 32'd0);

    stall_i = 1'b1;
    tick();
    check_eq("stall_hold", pc_o, 32'h108);
    stall_i = 1'b0;

    set_req(BR_COND, 32'h100, 32'hFFFF_FFF0, 32'h0, 1'b1, 1'b0);
    tick();
    check_eq("neg_off_pc", pc_o, 32'hF0);
    clr_req();
    tick(); tick();
    check_eq("neg_off_pc2",   pc_o, 32'hF8);
    check_eq("neg_off_flush", 32'(flush_o), 32'd0);

    // Wrapping JMP, then reset in the second flush cycle.
    set_req(BR_JMP, 32'hFFFF_FFFC, 32'h8, 32'h0, 1'b0, 1'b0);
    tick();
    check_eq("wrap_pc",    pc_o, 32'h4);
    check_eq("wrap_flush", 32'(flush_o), 32'd1);
    clr_req();
    tick();
    check_eq("wrap_pc2",    pc_o, 32'h8);
    check_eq("wrap_flush2", 32'(flush_o), 32'd1);
    rst = 1'b1;
    tick();
    check_eq("abort_pc",       pc_o, 32'h0);
    check_eq("abort_flush",    32'(flush_o), 32'd0);
    check_eq("abort_ready",    32'(bus.br_ready), 32'd1);
    check_eq("abort_pc_valid", 32'(pc_valid), 32'd0);
    rst = 1'b0;
    tick();
    check_eq("post_abort_pc",    pc_o, 32'h4);
    check_eq("post_abort_flush", 32'(flush_o), 32'd0);

`ifdef BRANCH_STATS_EN
    for (int i = 0; i < 5; i++) begin
      set_req(BR_JMP, 32'h0, 32'h40, 32'h0, 1'b0, 1'b0);
      tick();
      if (i >= 2) clr_req();
      tick();
      clr_req();
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      set_req(BR_COND, 32'h0, 32'h40, 32'h0, 1'b0, 1'b0);
      tick();
    end
    clr_req();
    tick();
    check_eq("stats_taken",    taken_cnt, 32'd5);
    check_eq("stats_nottaken", nottaken_cnt, 32'd3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Consumer of the condition ALU's z_flag; sits between decode/execute and fetch.
- Resolves conditional branches, direct jumps and register jumps, and owns the fetch PC register.
- Static predict-not-taken: fetch runs sequentially; any taken branch redirects the PC and flushes younger in-flight instructions for a fixed number of cycles.

Parameters:
RESET_PC, 32'h0000_0000, fetch PC loaded on reset
PC_STEP, 4, sequential PC increment and link offset
FLUSH_CYCLES, 2, cycles flush_o stays high after a taken redirect (min 1, max 15)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
stall_i  input  1  pipeline stall; holds the PC
br_valid  input  1  branch/jump request present
br_ready  output  1  request accepted this cycle when high together with br_valid
br_kind  input  2  request kind (`BR_COND, `BR_JMP, `BR_JREG, `BR_NONE)
br_link  input  1  write return address (JMP/JREG only)
br_pc  input  32  PC of the branch instruction
br_offset  input  32  signed PC-relative offset
br_reg  input  32  register target for JREG
z_flag  input  1  condition result from the condition ALU, same cycle as br_valid
pc_o  output  32  fetch PC
pc_valid  output  1  pc_o is valid for fetch
flush_o  output  1  kill younger in-flight instructions
link_we  output  1  one-cycle link write strobe
link_data  output  32  return address
misalign_o  output  1  one-cycle pulse: computed target had nonzero bits [1:0]

Behaviour:
- Reset, synchronous with priority over everything:
  - pc_o = RESET_PC; pc_valid = 0; flush_o = 0; link_we = 0; link_data = 0; misalign_o = 0.
  - State = RUN; flush counter = 0.
  - Reset asserted during FLUSH aborts the flush immediately.
- pc_valid goes to 1 on the first clock edge with rst low and stays 1.
- States:
  - RUN: br_ready = 1.
  - FLUSH: br_ready = 0. Any br_valid in FLUSH is a squashed instruction: dropped, no side effects, no misalign_o.
- Taken rule:
  - `BR_COND: taken = z_flag.
  - `BR_JMP, `BR_JREG: always taken.
  - `BR_NONE: never taken and produces no side effects.
- Target:
  - COND/JMP: br_pc + br_offset, 32-bit two's-complement, wraps mod 2^32 (0xFFFF_FFFC + 8 = 0x0000_0004).
  - JREG: br_reg.
  - Bits [1:0] are forced to 0. If they were nonzero and the branch is taken, misalign_o pulses in the cycle after acceptance.
- PC update per edge, in priority order: rst > taken accept in RUN > stall_i > increment.
  - Taken accept loads the target into pc_o. This wins over stall_i in the same cycle.
  - Otherwise stall_i high holds pc_o.
  - Otherwise pc_o += PC_STEP, wrapping.
- In FLUSH, the PC follows the stall/increment rules.
- Taken accept: next state = FLUSH with counter = FLUSH_CYCLES.
  - flush_o = 1 from the next cycle for exactly FLUSH_CYCLES cycles.
  - The counter decrements every cycle, ignoring stall_i.
  - Return to RUN when the counter reaches 0; br_ready is high that same cycle.
- Not-taken COND accept: no state change, no flush; the PC follows the normal stall/increment rules.
- Link:
  - Fires on an accepted JMP/JREG with br_link = 1.
  - link_we = 1 for one cycle after acceptance; link_data = br_pc + PC_STEP, wrapping.
  - br_link is ignored for COND.
  - link_data holds its last value when link_we = 0.
- Latency: request to redirected pc_o is 1 cycle. Back-to-back taken branches are separated by at least FLUSH_CYCLES+1 cycles.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- Defined:
  - Adds outputs taken_cnt[31:0] and nottaken_cnt[31:0], reset to 0.
  - Each increments by 1 on an accepted taken or not-taken branch. COND/JMP/JREG all count; NONE is not counted.
  - Both saturate at 0xFFFF_FFFF.
  - Dropped (squashed) requests are not counted.
- Undefined: the ports and the counters do not exist; all other behaviour is identical.

Decomposition:
- params.v holds the `BR_COND=2'b01, `BR_JMP=2'b10, `BR_JREG=2'b11, `BR_NONE=2'b00 codes and the state encodings RUN/FLUSH.
- One combinational sub-module, br_target_calc: computes target, taken and the misalign flag from br_kind, br_pc, br_offset, br_reg and z_flag.
- The FSM, PC register, counters and link logic stay in branch_resolve.

Test Plan:
- Reset, then 3 free-running cycles → pc_o = 0x0, 0x4, 0x8, 0xC; pc_valid 0 then 1; flush_o 0 throughout.
- COND at br_pc=0x10, offset=+0x20, z_flag=1 → pc_o = 0x30 next cycle; flush_o high exactly 2 cycles; br_ready low for 2 cycles; a br_valid injected during FLUSH has no effect.
- Same request with z_flag=0 → no flush; pc_o continues +4; br_ready stays 1.
- JREG br_reg=0x103, br_link=1, br_pc=0x40, with stall_i=1 the same cycle → pc_o = 0x100; misalign_o pulse; link_we pulse; link_data = 0x44.
- JMP br_pc=0xFFFF_FFFC, offset=+8 → pc_o = 0x0000_0004 (wrap). rst asserted during the 2nd flush cycle → pc_o = RESET_PC; flush_o = 0; br_ready = 1 next cycle.
- With BRANCH_STATS_EN: 5 taken and 3 not-taken accepted, plus 2 dropped during FLUSH → taken_cnt = 5, nottaken_cnt = 3.
